mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Shares the single ROM/RAM memory bus between the instruction-fetch port (m0) and the load/store port (m1) of the RISCV32I core. Arbitrates round-robin and decodes the memory map: ROM 0x000-0x3FF, RAM 0x400-0x4FF. Sequences each access with per-region wait states and drives the ROM/RAM chip selects and write enable. Unmapped, misaligned or ROM-write accesses return an error response and never reach memory.

Parameters:
ROM_WAIT, 1, extra access cycles for ROM reads (0-15)
RAM_WAIT, 0, extra access cycles for RAM reads and writes (0-15)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
m0_req  in  1  fetch request; held with m0_addr stable until m0_ack or m0_err
m0_addr  in  32  fetch byte address
m0_rdata  out  32  fetch read data; valid while m0_ack=1
m0_ack  out  1  one-cycle completion pulse
m0_err  out  1  one-cycle error pulse
m1_req  in  1  load/store request; held with addr, we and wdata stable until ack or err
m1_we  in  1  1 = write, 0 = read
m1_addr  in  32  load/store byte address
m1_wdata  in  32  store data
m1_rdata  out  32  load read data; valid while m1_ack=1
m1_ack  out  1  one-cycle completion pulse
m1_err  out  1  one-cycle error pulse
mem_addr  out  32  registered address to ROM/RAM
mem_wdata  out  32  registered write data to RAM
mem_rdata  in  32  read data from the selected memory, valid during the final access cycle
rom_cs  out  1  ROM chip select
ram_cs  out  1  RAM chip select
ram_we  out  1  RAM write enable

Behaviour:
- Reset (async, reset_n=0): state IDLE, last_grant=m0; all outputs 0 immediately, including mid-access.
- States: IDLE, ACCESS, RESP, ERR.
- IDLE: if exactly one req, grant it; if both, grant the port not granted last; after reset m1 wins the first tie. Latch port, addr, we and wdata. Update last_grant.
- Decode of the granted request: ROM if addr<=0x3FF; RAM if 0x400<=addr<=0x4FF. Error if addr[1:0]!=0, addr is unmapped, or the request is an m1 write to ROM. Error goes to ERR; a valid access loads wait_cnt with ROM_WAIT or RAM_WAIT and goes to ACCESS.
- ACCESS: mem_addr and mem_wdata are driven. Exactly one of rom_cs/ram_cs is 1. ram_we=ram_cs&we. If wait_cnt!=0, decrement it and stay. If wait_cnt=0, capture mem_rdata (reads) into the granted port's rdata register and go to RESP.
- Chip selects are asserted for exactly WAIT+1 cycles and are never both 1.
- RESP: the granted port's ack=1 for one cycle, rdata valid (writes return 0); then IDLE.
- ERR: the granted port's err=1 for one cycle; rdata=0; no cs/we asserted at any point; then IDLE.
- Latency: request sampled in IDLE at cycle 0 -> ack at cycle 2+WAIT, err at cycle 1.
- Throughput: the next grant is earliest in the cycle after RESP/ERR. The requester must drop or change req in the cycle after ack, so a stale req is never re-granted.
- The ungranted port's req is held pending; no ack/err is issued to it. A port never gets ack and err in the same cycle.
- Boundaries: 0x3FC is ROM, 0x400 is RAM, 0x4FC is RAM, 0x500 is error, 0xFFFFFFFC is error.

Optional Feature:
MEM_ARB_FAULT_CAPTURE_EN: adds input fault_clr (1) and outputs fault_valid (1), fault_addr (32) and fault_src (1, 0=m0, 1=m1).
- On the first ERR while fault_valid=0, latch the address and port and set fault_valid (sticky).
- Later errors do not overwrite the latched fault.
- fault_clr=1 clears fault_valid at the next edge. If it coincides with a new ERR, the new fault is captured.
- All three fault outputs reset to 0.
- Without the macro these ports and registers do not exist; errors are reported only via the err pulses.

Test Plan:
- RAM_WAIT=0: m1 write 0x400 data 0xDEADBEEF, then m1 read 0x400 -> ram_cs/ram_we high for 1 cycle, then ack at cycle 2 with m1_rdata=0xDEADBEEF.
- ROM_WAIT=1: m0 read 0x3FC -> rom_cs high for cycles 1-2, m0_ack at cycle 3, m0_rdata equals the ROM word.
- m0 and m1 both request from reset, held -> m1 granted first, then m0, then m1; no port starves.
- m1 read 0x500, m0 read 0x002, m1 write 0x100 -> err pulse at cycle 1 each, rom_cs/ram_cs/ram_we stay 0, rdata=0.
- reset_n low during ACCESS of a RAM write -> rom_cs/ram_cs/ram_we/ack drop immediately; after release a fresh request completes normally.
- With MEM_ARB_FAULT_CAPTURE_EN: errors at 0x500 (m1) then 0x600 (m0) -> fault_addr=0x500, fault_src=1; fault_clr -> fault_valid=0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter and address decoder sharing the ROM/RAM bus between fetch (m0) and load/store (m1).
// Optional fault capture registers are enabled by defining MEM_ARB_FAULT_CAPTURE_EN.
module mem_bus_arbiter #(
  parameter int ROM_WAIT = 1,
  parameter int RAM_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        rom_cs,
  output logic        ram_cs,
  output logic        ram_we
`ifdef MEM_ARB_FAULT_CAPTURE_EN
  ,
  input  logic        fault_clr,
  output logic        fault_valid,
  output logic [31:0] fault_addr,
  output logic        fault_src
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam logic [1:0] S_ERR    = 2'd3;

  localparam logic [3:0] ROM_WAIT_C = 4'(ROM_WAIT);
  localparam logic [3:0] RAM_WAIT_C = 4'(RAM_WAIT);

  logic [1:0]  r_state;
  logic        r_lastGrant;
  logic        r_port;
  logic        r_we;
  logic        r_isRom;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [3:0]  r_waitCnt;

  logic        w_anyReq;
  logic        w_grantPort;
  logic [31:0] w_gAddr;
  logic        w_gWe;
  logic [31:0] w_gWdata;
  logic        w_isRom;
  logic        w_isRam;
  logic        w_decErr;
  logic        w_access;

  // On a tie the port not served last wins, which keeps both masters from starving.
  always_comb begin
    w_anyReq    = m0_req | m1_req;
    w_grantPort = 1'b0;
    if (m0_req && m1_req) begin
      w_grantPort = ~r_lastGrant;
    end else if (m1_req) begin
      w_grantPort = 1'b1;
    end
    w_gAddr  = w_grantPort ? m1_addr : m0_addr;
    w_gWe    = w_grantPort & m1_we;
    w_gWdata = w_grantPort ? m1_wdata : 32'h0;
    w_isRom  = (w_gAddr <= 32'h0000_03FF);
    w_isRam  = (w_gAddr >= 32'h0000_0400) && (w_gAddr <= 32'h0000_04FF);
    w_decErr = (w_gAddr[1:0] != 2'b00) || !(w_isRom || w_isRam) || (w_isRom && w_gWe);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_lastGrant <= 1'b0;
      r_port      <= 1'b0;
      r_we        <= 1'b0;
      r_isRom     <= 1'b0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_rdata     <= 32'h0;
      r_waitCnt   <= 4'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_anyReq) begin
            r_port      <= w_grantPort;
            r_lastGrant <= w_grantPort;
            r_addr      <= w_gAddr;
            r_we        <= w_gWe;
            r_wdata     <= w_gWdata;
            r_isRom     <= w_isRom;
            r_rdata     <= 32'h0;
            if (w_decErr) begin
              r_state <= S_ERR;
            end else begin
              r_waitCnt <= w_isRom ? ROM_WAIT_C : RAM_WAIT_C;
              r_state   <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (r_waitCnt != 4'h0) begin
            r_waitCnt <= r_waitCnt - 4'h1;
          end else begin
            r_rdata <= r_we ? 32'h0 : mem_rdata;
            r_state <= S_RESP;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Everything below is decoded from registered state so reset silences the bus immediately.
  always_comb begin
    w_access  = (r_state == S_ACCESS);
    rom_cs    = w_access & r_isRom;
    ram_cs    = w_access & ~r_isRom;
    ram_we    = w_access & ~r_isRom & r_we;
    mem_addr  = w_access ? r_addr : 32'h0;
    mem_wdata = (w_access && r_we) ? r_wdata : 32'h0;
    m0_ack    = (r_state == S_RESP) & ~r_port;
    m1_ack    = (r_state == S_RESP) & r_port;
    m0_err    = (r_state == S_ERR) & ~r_port;
    m1_err    = (r_state == S_ERR) & r_port;
    m0_rdata  = m0_ack ? r_rdata : 32'h0;
    m1_rdata  = m1_ack ? r_rdata : 32'h0;
  end

`ifdef MEM_ARB_FAULT_CAPTURE_EN
  logic        r_faultValid;
  logic [31:0] r_faultAddr;
  logic        r_faultSrc;

  // First error is sticky; a clear coinciding with a new error re-arms and captures it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_faultValid <= 1'b0;
      r_faultAddr  <= 32'h0;
      r_faultSrc   <= 1'b0;
    end else if ((r_state == S_ERR) && (!r_faultValid || fault_clr)) begin
      r_faultValid <= 1'b1;
      r_faultAddr  <= r_addr;
      r_faultSrc   <= r_port;
    end else if (fault_clr) begin
      r_faultValid <= 1'b0;
    end
  end

  assign fault_valid = r_faultValid;
  assign fault_addr  = r_faultAddr;
  assign fault_src   = r_faultSrc;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table, hand sequences and randomized transactions
// checked against a transaction-level model. Fault capture checks compile under MEM_ARB_FAULT_CAPTURE_EN.
module tb_mem_bus_arbiter;
  localparam int ROM_W = 1;
  localparam int RAM_W = 0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_req, m0_ack, m0_err;
  logic [31:0] m0_addr, m0_rdata;
  logic        m1_req, m1_we, m1_ack, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        rom_cs, ram_cs, ram_we;
`ifdef MEM_ARB_FAULT_CAPTURE_EN
  logic        fault_clr, fault_valid, fault_src;
  logic [31:0] fault_addr;
`endif

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        expErr;
    logic [31:0] expRdata;
    int          expLat;
    int          expRom;
    int          expRam;
    int          expWe;
  } vec_t;

  vec_t vecs[12];
  logic [31:0] ramMem [0:63];
  logic [31:0] shadow [0:63];

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ROM_WAIT(ROM_W), .RAM_WAIT(RAM_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rom_cs(rom_cs), .ram_cs(ram_cs), .ram_we(ram_we)
`ifdef MEM_ARB_FAULT_CAPTURE_EN
    , .fault_clr(fault_clr), .fault_valid(fault_valid), .fault_addr(fault_addr), .fault_src(fault_src)
`endif
  );

  function automatic logic [31:0] romWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) + 32'h1234_5678;
  endfunction

  // Memory environment: ROM is a fixed pattern, RAM writes on the clock edge.
  assign mem_rdata = rom_cs ? romWord(mem_addr) : (ram_cs ? ramMem[mem_addr[7:2]] : 32'hBAD0_0BAD);
  always @(posedge clk) if (ram_we) ramMem[mem_addr[7:2]] <= mem_wdata;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0; m1_we = 1'b0;
    m0_addr = 32'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
`ifdef MEM_ARB_FAULT_CAPTURE_EN
    fault_clr = 1'b0;
`endif
    #1;
    checkOutput("reset_ctl", {25'h0, m0_ack, m0_err, m1_ack, m1_err, rom_cs, ram_cs, ram_we}, 32'h0);
    checkOutput("reset_data", m0_rdata | m1_rdata | mem_addr | mem_wdata, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic runTxn(input logic port, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic gotErr, output logic [31:0] gotRdata, output int gotLat,
                        output int romCnt, output int ramCnt, output int weCnt, output int badCnt);
    gotErr = 1'b0; gotRdata = 32'h0; gotLat = -1;
    romCnt = 0; ramCnt = 0; weCnt = 0; badCnt = 0;
    if (port) begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = 1'b1; m0_addr = addr;
    end
    for (int k = 1; k <= 40 && gotLat < 0; k++) begin
      @(posedge clk);
      #1;
      if (rom_cs) romCnt++;
      if (ram_cs) ramCnt++;
      if (ram_we) weCnt++;
      if (rom_cs && ram_cs) badCnt++;
      if (port ? (m0_ack | m0_err) : (m1_ack | m1_err)) badCnt++;
      if (port ? (m1_ack & m1_err) : (m0_ack & m0_err)) badCnt++;
      if (port ? (m1_ack | m1_err) : (m0_ack | m0_err)) begin
        gotLat   = k;
        gotErr   = port ? m1_err : m0_err;
        gotRdata = port ? m1_rdata : m0_rdata;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0; m1_we = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    logic        gErr;
    logic [31:0] gRd;
    int          gLat, gRom, gRam, gWe, gBad;
    runTxn(v.port, v.we, v.addr, v.wdata, gErr, gRd, gLat, gRom, gRam, gWe, gBad);
    checkOutput({tag, "_err"}, {31'h0, gErr}, {31'h0, v.expErr});
    checkOutput({tag, "_rdata"}, gRd, v.expRdata);
    checkOutput({tag, "_latency"}, 32'(gLat), 32'(v.expLat));
    checkOutput({tag, "_romCs"}, 32'(gRom), 32'(v.expRom));
    checkOutput({tag, "_ramCs"}, 32'(gRam), 32'(v.expRam));
    checkOutput({tag, "_ramWe"}, 32'(gWe), 32'(v.expWe));
    checkOutput({tag, "_protocol"}, 32'(gBad), 32'h0);
    if (!v.expErr && v.we) shadow[v.addr[7:2]] = v.wdata;
  endtask

  // Transaction-level reference: derives the whole outcome of one access from the memory map rules.
  function automatic vec_t predict(input logic port, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    vec_t v;
    logic isRom;
    v.port = port; v.we = we; v.addr = addr; v.wdata = wdata;
    isRom    = addr < 32'h400;
    v.expErr = (addr % 4 != 0) || (addr > 32'h4FF) || (port && we && isRom);
    v.expLat = v.expErr ? 1 : (isRom ? 2 + ROM_W : 2 + RAM_W);
    if (v.expErr || we) v.expRdata = 32'h0;
    else if (isRom)     v.expRdata = romWord(addr);
    else                v.expRdata = shadow[(addr - 32'h400) / 4];
    v.expRom = (!v.expErr && isRom)  ? ROM_W + 1 : 0;
    v.expRam = (!v.expErr && !isRom) ? RAM_W + 1 : 0;
    v.expWe  = we ? v.expRam : 0;
    return v;
  endfunction

  function automatic vec_t mk(input logic port, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic e, input logic [31:0] rd, input int lat, input int rc, input int ac, input int wc);
    vec_t v;
    v.port = port; v.we = we; v.addr = addr; v.wdata = wdata; v.expErr = e; v.expRdata = rd;
    v.expLat = lat; v.expRom = rc; v.expRam = ac; v.expWe = wc;
    return v;
  endfunction

  initial begin
    int order[$];
    int expOrder[4];
    logic rr0, rr1;
    vec_t v;
    logic [31:0] a;
    logic p, w;

    for (int i = 0; i < 64; i++) begin
      ramMem[i] = 32'h0;
      shadow[i] = 32'h0;
    end

    vecs[0]  = mk(1'b1, 1'b1, 32'h400, 32'hDEAD_BEEF, 1'b0, 32'h0, 2, 0, 1, 1);
    vecs[1]  = mk(1'b1, 1'b0, 32'h400, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 0, 1, 0);
    vecs[2]  = mk(1'b0, 1'b0, 32'h3FC, 32'h0, 1'b0, romWord(32'h3FC), 3, 2, 0, 0);
    vecs[3]  = mk(1'b1, 1'b1, 32'h4FC, 32'h1234_5678, 1'b0, 32'h0, 2, 0, 1, 1);
    vecs[4]  = mk(1'b0, 1'b0, 32'h4FC, 32'h0, 1'b0, 32'h1234_5678, 2, 0, 1, 0);
    vecs[5]  = mk(1'b1, 1'b0, 32'h500, 32'h0, 1'b1, 32'h0, 1, 0, 0, 0);
    vecs[6]  = mk(1'b0, 1'b0, 32'h002, 32'h0, 1'b1, 32'h0, 1, 0, 0, 0);
    vecs[7]  = mk(1'b1, 1'b1, 32'h100, 32'h55, 1'b1, 32'h0, 1, 0, 0, 0);
    vecs[8]  = mk(1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h0, 1, 0, 0, 0);
    vecs[9]  = mk(1'b1, 1'b0, 32'h000, 32'h0, 1'b0, romWord(32'h0), 3, 2, 0, 0);
    vecs[10] = mk(1'b1, 1'b0, 32'h3FD, 32'h0, 1'b1, 32'h0, 1, 0, 0, 0);
    vecs[11] = mk(1'b1, 1'b1, 32'h3FC, 32'hAAAA_5555, 1'b1, 32'h0, 1, 0, 0, 0);

    doReset();
    for (int i = 0; i < 12; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Both ports held from reset: m1 wins the first tie, then strict alternation.
    doReset();
    m0_addr = 32'h008; m1_addr = 32'h404; m1_we = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1;
    rr0 = 1'b0; rr1 = 1'b0;
    for (int c = 0; c < 60 && order.size() < 4; c++) begin
      @(posedge clk);
      #1;
      if (rr0) begin m0_req = 1'b1; rr0 = 1'b0; end
      if (rr1) begin m1_req = 1'b1; rr1 = 1'b0; end
      if (m0_ack) begin order.push_back(0); m0_req = 1'b0; rr0 = 1'b1; end
      if (m1_ack) begin order.push_back(1); m1_req = 1'b0; rr1 = 1'b1; end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expOrder = '{1, 0, 1, 0};
    checkOutput("tie_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("tie_order%0d", i), (i < order.size()) ? 32'(order[i]) : 32'hFFFF_FFFF, 32'(expOrder[i]));

    // Reset asserted in the middle of a RAM write access.
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h408; m1_wdata = 32'h1111_1111;
    @(posedge clk);
    #1;
    checkOutput("midrst_before", {30'h0, ram_cs, ram_we}, 32'h3);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_after", {27'h0, rom_cs, ram_cs, ram_we, m1_ack, m1_err}, 32'h0);
    m1_req = 1'b0; m1_we = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus(predict(1'b1, 1'b0, 32'h408, 32'h0), "midrst_noWrite");
    applyStimulus(predict(1'b1, 1'b1, 32'h40C, 32'hCAFE_F00D), "midrst_write");
    applyStimulus(predict(1'b1, 1'b0, 32'h40C, 32'h0), "midrst_read");

    for (int i = 0; i < 80; i++) begin
      p = 1'($urandom_range(0, 1));
      w = p ? 1'($urandom_range(0, 1)) : 1'b0;
      case ($urandom_range(0, 4))
        0: a = 32'($urandom_range(0, 255)) << 2;
        1, 2: a = 32'h400 + (32'($urandom_range(0, 63)) << 2);
        3: a = (32'($urandom_range(0, 32'h13F)) << 2) | 32'($urandom_range(1, 3));
        default: begin
          a = $urandom;
          a[1:0] = 2'b00;
          if (a < 32'h500) a = a + 32'h500;
        end
      endcase
      v = predict(p, w, a, $urandom);
      applyStimulus(v, $sformatf("rand%0d", i));
    end

`ifdef MEM_ARB_FAULT_CAPTURE_EN
    doReset();
    checkOutput("fault_reset", {30'h0, fault_valid, fault_src} | fault_addr, 32'h0);
    applyStimulus(predict(1'b1, 1'b0, 32'h500, 32'h0), "fault_e1");
    applyStimulus(predict(1'b0, 1'b0, 32'h600, 32'h0), "fault_e2");
    checkOutput("fault_valid", {31'h0, fault_valid}, 32'h1);
    checkOutput("fault_addr", fault_addr, 32'h500);
    checkOutput("fault_src", {31'h0, fault_src}, 32'h1);
    fault_clr = 1'b1;
    @(posedge clk);
    #1;
    fault_clr = 1'b0;
    checkOutput("fault_cleared", {31'h0, fault_valid}, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
